// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// Result, sign and overflow are held between conversions for a downstream display driver.
module bin_to_bcd_seq #(
    parameter int N_BIN  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_BIN-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   BCD_out,
    output logic                  neg,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(N_BIN) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_BIN-1:0] bin_q, bin_d;
    logic [BW-1:0]    scr_q, scr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             neg_int_q, neg_int_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [N_BIN-1:0] mag;
    logic             neg_in;
    logic [BW-1:0]    adj;

    // Handshake: start is taken only in IDLE; busy is high in every other state;
    // done pulses for one cycle as the new result appears on BCD_out/neg/overflow.
    always_comb begin
        mag    = bin_in;
        neg_in = 1'b0;
        if (SIGNED && bin_in[N_BIN-1]) begin
            mag    = -bin_in;
            neg_in = 1'b1;
        end

        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        neg_int_d = neg_int_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d     = mag;
                    scr_d     = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = '0;
                    neg_int_d = neg_in;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A set MSB in the adjusted top digit would be shifted out: the value does not fit.
                sticky_d       = sticky_q | adj[BW-1];
                {scr_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_BIN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = sticky_q ? {BW{1'b1}} : scr_q;
                neg_d   = SIGNED ? neg_int_q : 1'b0;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            neg_int_q <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            neg_int_q <= neg_int_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign BCD_out   = bcd_q;
    assign neg       = neg_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three parameterisations share one clock and reset;
// expected results come from a decimal reference model or directed constants.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst_n;

  // DUT A: defaults (16-bit unsigned, 5 digits)
  logic        a_start;
  logic [15:0] a_bin;
  logic [19:0] a_bcd;
  logic        a_neg, a_ovf, a_busy, a_done;
  logic [1:0]  a_state;

  // DUT B: 16-bit unsigned, 4 digits
  logic        b_start;
  logic [15:0] b_bin;
  logic [15:0] b_bcd;
  logic        b_neg, b_ovf, b_busy, b_done;
  logic [1:0]  b_state;

  // DUT C: 8-bit signed, 3 digits
  logic        c_start;
  logic [7:0]  c_bin;
  logic [11:0] c_bcd;
  logic        c_neg, c_ovf, c_busy, c_done;
  logic [1:0]  c_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  bin_to_bcd_seq u_a (
    .clock(clk), .reset(rst_n), .start(a_start), .bin_in(a_bin),
    .BCD_out(a_bcd), .neg(a_neg), .overflow(a_ovf), .busy(a_busy),
    .done(a_done), .state_dbg(a_state)
  );

  bin_to_bcd_seq #(.N_BIN(16), .DIGITS(4), .SIGNED(1'b0)) u_b (
    .clock(clk), .reset(rst_n), .start(b_start), .bin_in(b_bin),
    .BCD_out(b_bcd), .neg(b_neg), .overflow(b_ovf), .busy(b_busy),
    .done(b_done), .state_dbg(b_state)
  );

  bin_to_bcd_seq #(.N_BIN(8), .DIGITS(3), .SIGNED(1'b1)) u_c (
    .clock(clk), .reset(rst_n), .start(c_start), .bin_in(c_bin),
    .BCD_out(c_bcd), .neg(c_neg), .overflow(c_ovf), .busy(c_busy),
    .done(c_done), .state_dbg(c_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: packs {ovf, neg, bcd} with bcd at [4*digits-1:0]
  function automatic logic [31:0] model(input logic [31:0] raw, input int nbin,
                                        input int digits, input bit sgn);
    longint unsigned mag;
    longint unsigned lim;
    logic [31:0] r;
    bit n;
    mag = longint'(raw) & ((64'd1 << nbin) - 64'd1);
    n = 1'b0;
    if (sgn && raw[nbin-1]) begin
      mag = (64'd1 << nbin) - mag;
      n = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r = '0;
    if (mag >= lim) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'hF;
      r[4*digits+1] = 1'b1;
    end else begin
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
    r[4*digits] = n;
    return r;
  endfunction

  function automatic logic [31:0] obs(input int which);
    case (which)
      0:       return 32'({a_ovf, a_neg, a_bcd});
      1:       return 32'({b_ovf, b_neg, b_bcd});
      default: return 32'({c_ovf, c_neg, c_bcd});
    endcase
  endfunction

  function automatic logic cur_busy(input int which);
    case (which)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic cur_done(input int which);
    case (which)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input int which, input logic s, input logic [31:0] v);
    case (which)
      0:       begin a_start = s; a_bin = v[15:0]; end
      1:       begin b_start = s; b_bin = v[15:0]; end
      default: begin c_start = s; c_bin = v[7:0]; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one start, optionally re-pulses start at cycle pulse_at while busy,
  // and scoreboards the result when done appears.
  task automatic conv(input int which, input logic [31:0] v, input logic [31:0] exp_w,
                      input int exp_lat, input int pulse_at, input logic [31:0] pulse_v);
    int lat;
    int bc;
    logic [31:0] e;
    drive(which, 1'b1, v);
    exp_q.push_back(exp_w);
    @(negedge clk);
    drive(which, 1'b0, $urandom);
    check("accept_busy_done", {30'd0, cur_busy(which), cur_done(which)}, 32'd2);
    lat = 0;
    bc = cur_busy(which) ? 1 : 0;
    while (!cur_done(which) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) drive(which, 1'b1, pulse_v);
      else drive(which, 1'b0, $urandom);
      if (cur_busy(which)) bc++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(bc), 32'(exp_lat));
    e = exp_q.pop_front();
    check("result", obs(which), e);
  endtask

  initial begin
    int nd;
    logic [31:0] v;
    checks = 0;
    failures = 0;
    a_start = 1'b0; a_bin = '0;
    b_start = 1'b0; b_bin = '0;
    c_start = 1'b0; c_bin = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({a_ovf, a_neg, a_busy, a_done, a_bcd}), 32'd0);
    check("reset_b", 32'({b_ovf, b_neg, b_busy, b_done, b_bcd}), 32'd0);
    check("reset_c", 32'({c_ovf, c_neg, c_busy, c_done, c_bcd}), 32'd0);
    rst_n = 1'b1;

    // default parameters
    conv(0, 32'hFFFF, 32'h065535, 17, -1, 0);
    conv(0, 32'd0, model(32'd0, 16, 5, 1'b0), 17, -1, 0);
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 65535);
      conv(0, v, model(v, 16, 5, 1'b0), 17, -1, 0);
    end

    // four digits: largest fitting value and overflow boundary
    conv(1, 32'd9999, 32'h09999, 17, -1, 0);
    conv(1, 32'd12345, 32'h2FFFF, 17, -1, 0);
    conv(1, 32'd10000, model(32'd10000, 16, 4, 1'b0), 17, -1, 0);

    // signed, 8-bit, 3 digits
    conv(2, 32'h80, 32'h1128, 9, -1, 0);
    conv(2, 32'hFF, 32'h1001, 9, -1, 0);
    conv(2, 32'h7F, 32'h0127, 9, -1, 0);
    conv(2, 32'h00, 32'h0000, 9, -1, 0);

    // start while busy is ignored; start in the done cycle is accepted
    conv(0, 32'd42, 32'h000042, 17, 5, 32'd7);
    conv(0, 32'd7, 32'h000007, 17, -1, 0);

    // reset during a conversion
    conv(0, 32'd300, model(32'd300, 16, 5, 1'b0), 17, -1, 0);
    drive(0, 1'b1, 32'd500);
    @(negedge clk);
    drive(0, 1'b0, 32'd500);
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({a_ovf, a_neg, a_busy, a_done, a_bcd}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    check("no_done_after_abort", 32'(nd), 32'd0);
    conv(0, 32'd500, model(32'd500, 16, 5, 1'b0), 17, -1, 0);

    // hold: outputs stay put while bin_in wanders with start low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold", 32'({a_busy, a_done, a_ovf, a_neg, a_bcd}), model(32'd500, 16, 5, 1'b0));
      a_bin = 16'($urandom);
      a_start = 1'b0;
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
